rbcp_wb_xbar: RTL and testbench

Parametrised RBCP-to-Wishbone bridge and address crossbar for the SiTCP register path. It decodes each RBCP byte access against NUM_TARGETS base/mask windows and runs one single-beat Wishbone cycle to the matching target. It supervises that cycle with a timeout and slave-error handling, and returns RBCP_ACK and RBCP_RD. It replaces the fixed five-region decode and the separate bridge, and adds error status counters for the system register table.

---
 rtl/rbcp_wb_pkg.sv | 18 +
 rtl/rbcp_wb_decode.sv | 27 ++
 rtl/rbcp_wb_xbar.sv | 228 ++++++++++++++++++++++
 tb/tb_rbcp_wb_xbar.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rbcp_wb_pkg.sv
// Shared types and constants for the RBCP-to-Wishbone bridge/crossbar.
// Holds the FSM state encoding, error codes and status counter width.
package rbcp_wb_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WB   = 2'd1,
      ST_RESP = 2'd2
   } state_t;

   localparam logic [1:0] ERR_NONE  = 2'b00;
   localparam logic [1:0] ERR_NODEC = 2'b01;
   localparam logic [1:0] ERR_TMO   = 2'b10;
   localparam logic [1:0] ERR_SLV   = 2'b11;

   localparam int ERR_CNT_W = 16;

endpackage

// File: rtl/rbcp_wb_decode.sv
// Combinational priority address matcher: one base/mask window per target,
// lowest matching index wins, result is a one-hot select plus a hit flag.
module rbcp_wb_decode
   import rbcp_wb_pkg::*;
#(
   parameter int                         NUM_TARGETS = 8,
   parameter logic [32*NUM_TARGETS-1:0]  TARGET_BASE = {NUM_TARGETS{32'h0}},
   parameter logic [32*NUM_TARGETS-1:0]  TARGET_MASK = {NUM_TARGETS{32'hFFFF_FF00}}
) (
   input  logic [31:0]            addr_i,
   output logic [NUM_TARGETS-1:0] sel_o,
   output logic                   hit_o
);

   // Once a window has hit, later (higher-index) windows are masked off.
   always_comb begin
      sel_o = '0;
      hit_o = 1'b0;
      for (int i = 0; i < NUM_TARGETS; i++) begin
         if (!hit_o && ((addr_i & TARGET_MASK[32*i +: 32]) == TARGET_BASE[32*i +: 32])) begin
            sel_o[i] = 1'b1;
            hit_o    = 1'b1;
         end
      end
   end

endmodule

// File: rtl/rbcp_wb_xbar.sv
// RBCP-to-Wishbone bridge with address crossbar: decodes each RBCP access,
// runs one supervised single-beat Wishbone cycle and keeps error status.
module rbcp_wb_xbar
   import rbcp_wb_pkg::*;
#(
   parameter int                         NUM_TARGETS  = 8,
   parameter logic [32*NUM_TARGETS-1:0]  TARGET_BASE  = {NUM_TARGETS{32'h0}},
   parameter logic [32*NUM_TARGETS-1:0]  TARGET_MASK  = {NUM_TARGETS{32'hFFFF_FF00}},
   parameter int                         WB_ADR_W     = 16,
   parameter int                         TIMEOUT_CYC  = 255,
   parameter logic [7:0]                 ERR_DATA     = 8'hEE,
   parameter bit                         ACK_ON_ERROR = 1'b1
) (
   input  logic                       CLK,
   input  logic                       RST,
   input  logic                       RBCP_ACT,
   input  logic [31:0]                RBCP_ADDR,
   input  logic                       RBCP_WE,
   input  logic [7:0]                 RBCP_WD,
   input  logic                       RBCP_RE,
   output logic [7:0]                 RBCP_RD,
   output logic                       RBCP_ACK,
   output logic [WB_ADR_W-1:0]        WB_ADR,
   output logic [7:0]                 WB_DAT_O,
   output logic                       WB_WE,
   output logic                       WB_CYC,
   output logic [NUM_TARGETS-1:0]     WB_STB,
   input  logic [8*NUM_TARGETS-1:0]   WB_DAT_I,
   input  logic [NUM_TARGETS-1:0]     WB_ACK_I,
   input  logic [NUM_TARGETS-1:0]     WB_ERR_I,
   input  logic                       ERR_CLR,
   output logic [ERR_CNT_W-1:0]       ERR_CNT,
   output logic [31:0]                LAST_ERR_ADDR,
   output logic [1:0]                 LAST_ERR_CODE,
   output logic                       BUSY
);

   state_t                 state_q, state_d;
   logic [31:0]            addr_q, addr_d;
   logic [7:0]             wd_q, wd_d;
   logic                   we_q, we_d;
   logic                   cyc_q, cyc_d;
   logic [NUM_TARGETS-1:0] stb_q, stb_d;
   logic [15:0]            tmo_q, tmo_d;
   logic                   ack_q, ack_d;
   logic [7:0]             rd_q, rd_d;
   logic [ERR_CNT_W-1:0]   errCnt_q, errCnt_d;
   logic [31:0]            errAddr_q, errAddr_d;
   logic [1:0]             errCode_q, errCode_d;

   logic [NUM_TARGETS-1:0] decSel;
   logic                   decHit;
   logic                   strobe;
   logic                   selAck;
   logic                   selErr;
   logic [7:0]             rdMux;
   logic [16:0]            tmoNext;
   logic                   failEvt;
   logic                   dropEvt;
   logic [1:0]             failCode;
   logic [31:0]            failAddr;
   logic [ERR_CNT_W:0]     cntSum;

   rbcp_wb_decode #(
      .NUM_TARGETS (NUM_TARGETS),
      .TARGET_BASE (TARGET_BASE),
      .TARGET_MASK (TARGET_MASK)
   ) u_decode (
      .addr_i (RBCP_ADDR),
      .sel_o  (decSel),
      .hit_o  (decHit)
   );

   // Only the currently strobed target may answer; its data lane is selected by the one-hot strobe.
   always_comb begin
      strobe  = RBCP_ACT && (RBCP_WE || RBCP_RE);
      selAck  = |(WB_ACK_I & stb_q);
      selErr  = |(WB_ERR_I & stb_q);
      tmoNext = {1'b0, tmo_q} + 17'd1;
      rdMux   = 8'h00;
      for (int i = 0; i < NUM_TARGETS; i++) begin
         if (stb_q[i]) begin
            rdMux = rdMux | WB_DAT_I[8*i +: 8];
         end
      end
   end

   // Next-state logic; leaving WB for RESP always drops CYC/STB in the same step.
   always_comb begin
      state_d  = state_q;
      addr_d   = addr_q;
      wd_d     = wd_q;
      we_d     = we_q;
      cyc_d    = cyc_q;
      stb_d    = stb_q;
      tmo_d    = tmo_q;
      ack_d    = 1'b0;
      rd_d     = 8'h00;
      failEvt  = 1'b0;
      dropEvt  = 1'b0;
      failCode = ERR_NONE;
      failAddr = addr_q;

      case (state_q)
         ST_IDLE: begin
            if (strobe) begin
               addr_d = RBCP_ADDR;
               wd_d   = RBCP_WD;
               we_d   = RBCP_WE;
               tmo_d  = 16'd0;
               if (decHit) begin
                  state_d = ST_WB;
                  cyc_d   = 1'b1;
                  stb_d   = decSel;
               end else begin
                  state_d  = ST_RESP;
                  ack_d    = ACK_ON_ERROR;
                  rd_d     = ERR_DATA;
                  failEvt  = 1'b1;
                  failCode = ERR_NODEC;
                  failAddr = RBCP_ADDR;
               end
            end
         end
         ST_WB: begin
            dropEvt = strobe;
            if (!RBCP_ACT) begin
               state_d = ST_IDLE;
               cyc_d   = 1'b0;
               stb_d   = '0;
            end else if (selErr) begin
               state_d  = ST_RESP;
               cyc_d    = 1'b0;
               stb_d    = '0;
               ack_d    = ACK_ON_ERROR;
               rd_d     = ERR_DATA;
               failEvt  = 1'b1;
               failCode = ERR_SLV;
            end else if (selAck) begin
               state_d = ST_RESP;
               cyc_d   = 1'b0;
               stb_d   = '0;
               ack_d   = 1'b1;
               rd_d    = we_q ? 8'h00 : rdMux;
            end else if (tmoNext == 17'(TIMEOUT_CYC)) begin
               state_d  = ST_RESP;
               cyc_d    = 1'b0;
               stb_d    = '0;
               ack_d    = ACK_ON_ERROR;
               rd_d     = ERR_DATA;
               failEvt  = 1'b1;
               failCode = ERR_TMO;
            end else begin
               tmo_d = tmoNext[15:0];
            end
         end
         ST_RESP: begin
            dropEvt = strobe;
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
            cyc_d   = 1'b0;
            stb_d   = '0;
         end
      endcase
   end

   // A failure and a dropped strobe may land on the same edge, so up to two counts are added.
   always_comb begin
      cntSum    = {1'b0, errCnt_q} + {{ERR_CNT_W{1'b0}}, failEvt} + {{ERR_CNT_W{1'b0}}, dropEvt};
      errCnt_d  = cntSum[ERR_CNT_W] ? {ERR_CNT_W{1'b1}} : cntSum[ERR_CNT_W-1:0];
      errAddr_d = errAddr_q;
      errCode_d = errCode_q;
      if (failEvt) begin
         errAddr_d = failAddr;
         errCode_d = failCode;
      end
      if (ERR_CLR) begin
         errCnt_d  = '0;
         errAddr_d = 32'h0;
         errCode_d = ERR_NONE;
      end
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_q   <= ST_IDLE;
         addr_q    <= 32'h0;
         wd_q      <= 8'h00;
         we_q      <= 1'b0;
         cyc_q     <= 1'b0;
         stb_q     <= '0;
         tmo_q     <= 16'd0;
         ack_q     <= 1'b0;
         rd_q      <= 8'h00;
         errCnt_q  <= '0;
         errAddr_q <= 32'h0;
         errCode_q <= ERR_NONE;
      end else begin
         state_q   <= state_d;
         addr_q    <= addr_d;
         wd_q      <= wd_d;
         we_q      <= we_d;
         cyc_q     <= cyc_d;
         stb_q     <= stb_d;
         tmo_q     <= tmo_d;
         ack_q     <= ack_d;
         rd_q      <= rd_d;
         errCnt_q  <= errCnt_d;
         errAddr_q <= errAddr_d;
         errCode_q <= errCode_d;
      end
   end

   assign RBCP_ACK      = ack_q;
   assign RBCP_RD       = rd_q;
   assign WB_ADR        = addr_q[WB_ADR_W-1:0];
   assign WB_DAT_O      = wd_q;
   assign WB_WE         = we_q;
   assign WB_CYC        = cyc_q;
   assign WB_STB        = stb_q;
   assign ERR_CNT       = errCnt_q;
   assign LAST_ERR_ADDR = errAddr_q;
   assign LAST_ERR_CODE = errCode_q;
   assign BUSY          = (state_q != ST_IDLE);

endmodule

// File: tb/tb_rbcp_wb_xbar.sv
// Directed scoreboard bench for rbcp_wb_xbar: one instance acknowledges
// failures with ERR_DATA, a second one with ACK_ON_ERROR=0 suppresses them.
module tb_rbcp_wb_xbar;
   import rbcp_wb_pkg::*;

   localparam int NT = 4;
   localparam logic [32*NT-1:0] BASES = {32'h0002_0000, 32'h0002_0000, 32'h0001_0000, 32'h0000_0000};
   localparam logic [32*NT-1:0] MASKS = {32'hFFFF_0000, 32'hFFFF_FF00, 32'hFFFF_FF00, 32'hFFFF_FF00};

   logic          CLK;
   logic          RST;
   logic          RBCP_ACT;
   logic [31:0]   RBCP_ADDR;
   logic          RBCP_WE;
   logic [7:0]    RBCP_WD;
   logic          RBCP_RE;
   logic [8*NT-1:0] WB_DAT_I;
   logic [NT-1:0] WB_ACK_I;
   logic [NT-1:0] WB_ERR_I;
   logic          ERR_CLR;

   logic [7:0]    RBCP_RD, rdB;
   logic          RBCP_ACK, ackB;
   logic [15:0]   WB_ADR, wbAdrB;
   logic [7:0]    WB_DAT_O, wbDatB;
   logic          WB_WE, wbWeB;
   logic          WB_CYC, wbCycB;
   logic [NT-1:0] WB_STB, wbStbB;
   logic [15:0]   ERR_CNT, errCntB;
   logic [31:0]   LAST_ERR_ADDR, errAddrB;
   logic [1:0]    LAST_ERR_CODE, errCodeB;
   logic          BUSY, busyB;

   int checks = 0;
   int errors = 0;
   int expCnt = 0;
   logic [7:0] sbA[$];
   logic [7:0] sbB[$];

   rbcp_wb_xbar #(
      .NUM_TARGETS(NT), .TARGET_BASE(BASES), .TARGET_MASK(MASKS), .WB_ADR_W(16),
      .TIMEOUT_CYC(8), .ERR_DATA(8'hEE), .ACK_ON_ERROR(1'b1)
   ) dut (
      .CLK(CLK), .RST(RST), .RBCP_ACT(RBCP_ACT), .RBCP_ADDR(RBCP_ADDR), .RBCP_WE(RBCP_WE),
      .RBCP_WD(RBCP_WD), .RBCP_RE(RBCP_RE), .RBCP_RD(RBCP_RD), .RBCP_ACK(RBCP_ACK),
      .WB_ADR(WB_ADR), .WB_DAT_O(WB_DAT_O), .WB_WE(WB_WE), .WB_CYC(WB_CYC), .WB_STB(WB_STB),
      .WB_DAT_I(WB_DAT_I), .WB_ACK_I(WB_ACK_I), .WB_ERR_I(WB_ERR_I), .ERR_CLR(ERR_CLR),
      .ERR_CNT(ERR_CNT), .LAST_ERR_ADDR(LAST_ERR_ADDR), .LAST_ERR_CODE(LAST_ERR_CODE), .BUSY(BUSY)
   );

   rbcp_wb_xbar #(
      .NUM_TARGETS(NT), .TARGET_BASE(BASES), .TARGET_MASK(MASKS), .WB_ADR_W(16),
      .TIMEOUT_CYC(8), .ERR_DATA(8'hEE), .ACK_ON_ERROR(1'b0)
   ) dutB (
      .CLK(CLK), .RST(RST), .RBCP_ACT(RBCP_ACT), .RBCP_ADDR(RBCP_ADDR), .RBCP_WE(RBCP_WE),
      .RBCP_WD(RBCP_WD), .RBCP_RE(RBCP_RE), .RBCP_RD(rdB), .RBCP_ACK(ackB),
      .WB_ADR(wbAdrB), .WB_DAT_O(wbDatB), .WB_WE(wbWeB), .WB_CYC(wbCycB), .WB_STB(wbStbB),
      .WB_DAT_I(WB_DAT_I), .WB_ACK_I(WB_ACK_I), .WB_ERR_I(WB_ERR_I), .ERR_CLR(ERR_CLR),
      .ERR_CNT(errCntB), .LAST_ERR_ADDR(errAddrB), .LAST_ERR_CODE(errCodeB), .BUSY(busyB)
   );

   initial begin
      CLK = 1'b0;
      forever #5 CLK = ~CLK;
   end

   // Every comparison funnels through here so the counters stay in one place.
   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic checkStatus(input logic [1:0] code, input logic [31:0] addr);
      checkOutput("errCnt", ERR_CNT, expCnt);
      checkOutput("errCode", LAST_ERR_CODE, code);
      checkOutput("errAddr", LAST_ERR_ADDR, addr);
      checkOutput("errCntB", errCntB, expCnt);
      checkOutput("errCodeB", errCodeB, code);
      checkOutput("errAddrB", errAddrB, addr);
   endtask

   // kind: 0 silent, 1 ack, 2 err, 3 ack+err, 4 stray ack from another target then real ack.
   task automatic applyStimulus(input logic isWrite, input logic [31:0] addr, input logic [7:0] wd,
                                input int kind, input int respAt, input int expTgt, input int expStb,
                                input logic ackExpA, input logic [7:0] expRd, input logic ackExpB);
      int stbCnt, ackCntA, ackCntBv, ackAtA, stbBad;
      logic [NT-1:0] tgtMask, otherMask;
      logic [7:0] expV;
      tgtMask   = NT'(1 << expTgt);
      otherMask = NT'(1 << ((expTgt + 1) % NT));
      stbCnt = 0; ackCntA = 0; ackCntBv = 0; ackAtA = -1; stbBad = 0;
      @(negedge CLK);
      RBCP_ADDR = addr;
      RBCP_WD   = wd;
      RBCP_WE   = isWrite;
      RBCP_RE   = !isWrite;
      if (ackExpA) sbA.push_back(expRd);
      if (ackExpB) sbB.push_back(expRd);
      @(negedge CLK);
      RBCP_WE = 1'b0;
      RBCP_RE = 1'b0;
      for (int c = 0; c < 40; c++) begin
         WB_ACK_I = '0;
         WB_ERR_I = '0;
         if (WB_STB != '0) begin
            stbCnt++;
            if (WB_STB != tgtMask) stbBad++;
            if (stbCnt == 1) begin
               checkOutput("stbSel", WB_STB, tgtMask);
               checkOutput("cyc", WB_CYC, 1);
               checkOutput("adr", WB_ADR, addr[15:0]);
               checkOutput("we", WB_WE, isWrite);
               checkOutput("stbSelB", wbStbB, tgtMask);
               checkOutput("cycB", wbCycB, 1);
               checkOutput("adrB", wbAdrB, addr[15:0]);
               checkOutput("weB", wbWeB, isWrite);
               if (isWrite) begin
                  checkOutput("datO", WB_DAT_O, wd);
                  checkOutput("datOB", wbDatB, wd);
               end
            end
            case (kind)
               1: if (stbCnt == respAt) WB_ACK_I = tgtMask;
               2: if (stbCnt == respAt) WB_ERR_I = tgtMask;
               3: if (stbCnt == respAt) begin WB_ACK_I = tgtMask; WB_ERR_I = tgtMask; end
               4: begin
                  if (stbCnt == respAt) WB_ACK_I = otherMask;
                  if (stbCnt == respAt + 2) WB_ACK_I = tgtMask;
               end
               default: ;
            endcase
         end
         if (RBCP_ACK) begin
            ackCntA++;
            if (ackCntA == 1) ackAtA = c;
            if (sbA.size() > 0) begin
               expV = sbA.pop_front();
               checkOutput("rdA", RBCP_RD, expV);
            end
         end
         if (ackB) begin
            ackCntBv++;
            if (sbB.size() > 0) begin
               expV = sbB.pop_front();
               checkOutput("rdB", rdB, expV);
            end
         end
         @(negedge CLK);
      end
      WB_ACK_I = '0;
      WB_ERR_I = '0;
      checkOutput("stbCycles", stbCnt, expStb);
      checkOutput("stbStable", stbBad, 0);
      checkOutput("ackCount", ackCntA, ackExpA);
      checkOutput("ackCountB", ackCntBv, ackExpB);
      if (ackExpA) checkOutput("ackLatency", ackAtA, expStb);
      checkOutput("busyEnd", BUSY, 0);
      checkOutput("busyEndB", busyB, 0);
      sbA.delete();
      sbB.delete();
   endtask

   // Linear directed sequence; expected status values are tracked in expCnt and literals.
   initial begin
      int ackSeen;
      RST = 1'b1; RBCP_ACT = 1'b0; RBCP_ADDR = 32'h0; RBCP_WE = 1'b0; RBCP_WD = 8'h00;
      RBCP_RE = 1'b0; WB_ACK_I = '0; WB_ERR_I = '0; ERR_CLR = 1'b0;
      WB_DAT_I = {8'h33, 8'h5A, 8'h22, 8'h11};
      repeat (2) @(negedge CLK);
      checkOutput("rstAck", RBCP_ACK, 0);
      checkOutput("rstRd", RBCP_RD, 0);
      checkOutput("rstCyc", WB_CYC, 0);
      checkOutput("rstStb", WB_STB, 0);
      checkOutput("rstBusy", BUSY, 0);
      checkStatus(ERR_NONE, 32'h0);
      RST = 1'b0;
      RBCP_ACT = 1'b1;
      @(negedge CLK);

      $display("[TB] read target 2 with 3 wait states");
      applyStimulus(1'b0, 32'h0002_0005, 8'h00, 1, 4, 2, 4, 1'b1, 8'h5A, 1'b1);
      checkStatus(ERR_NONE, 32'h0);

      $display("[TB] zero-wait write to target 0");
      applyStimulus(1'b1, 32'h0000_0010, 8'hC3, 1, 1, 0, 1, 1'b1, 8'h00, 1'b1);

      $display("[TB] read target 3 only window");
      applyStimulus(1'b0, 32'h0002_0105, 8'h00, 1, 2, 3, 2, 1'b1, 8'h33, 1'b1);

      $display("[TB] no-decode read");
      applyStimulus(1'b0, 32'h1234_0000, 8'h00, 0, 0, 0, 0, 1'b1, 8'hEE, 1'b0);
      expCnt = 1;
      checkStatus(ERR_NODEC, 32'h1234_0000);

      $display("[TB] timeout on silent target 1");
      applyStimulus(1'b0, 32'h0001_0000, 8'h00, 0, 0, 1, 8, 1'b1, 8'hEE, 1'b0);
      expCnt = 2;
      checkStatus(ERR_TMO, 32'h0001_0000);

      $display("[TB] simultaneous ERR and ACK");
      applyStimulus(1'b0, 32'h0002_0001, 8'h00, 3, 2, 2, 2, 1'b1, 8'hEE, 1'b0);
      expCnt = 3;
      checkStatus(ERR_SLV, 32'h0002_0001);

      $display("[TB] stray ack from non-selected target");
      applyStimulus(1'b0, 32'h0001_0003, 8'h00, 4, 1, 1, 3, 1'b1, 8'h22, 1'b1);
      checkStatus(ERR_SLV, 32'h0002_0001);

      $display("[TB] dropped strobe while busy, then session abort");
      @(negedge CLK);
      RBCP_ADDR = 32'h0001_0000; RBCP_RE = 1'b1;
      @(negedge CLK);
      RBCP_RE = 1'b0;
      @(negedge CLK);
      RBCP_RE = 1'b1;
      @(negedge CLK);
      RBCP_RE = 1'b0;
      expCnt = 4;
      checkOutput("busyInWb", BUSY, 1);
      checkStatus(ERR_SLV, 32'h0002_0001);
      RBCP_ACT = 1'b0;
      @(negedge CLK);
      checkOutput("abortCyc", WB_CYC, 0);
      checkOutput("abortStb", WB_STB, 0);
      checkOutput("abortBusy", BUSY, 0);
      RBCP_ADDR = 32'h0002_0005; RBCP_RE = 1'b1;
      @(negedge CLK);
      RBCP_RE = 1'b0;
      ackSeen = 0;
      for (int c = 0; c < 12; c++) begin
         if (RBCP_ACK || ackB || (WB_STB != '0)) ackSeen++;
         @(negedge CLK);
      end
      checkOutput("abortQuiet", ackSeen, 0);
      checkStatus(ERR_SLV, 32'h0002_0001);
      RBCP_ACT = 1'b1;

      $display("[TB] reset during Wishbone cycle");
      @(negedge CLK);
      RBCP_ADDR = 32'h0002_0005; RBCP_RE = 1'b1;
      @(negedge CLK);
      RBCP_RE = 1'b0;
      @(negedge CLK);
      checkOutput("preRstCyc", WB_CYC, 1);
      #2 RST = 1'b1;
      #1;
      checkOutput("midRstCyc", WB_CYC, 0);
      checkOutput("midRstStb", WB_STB, 0);
      checkOutput("midRstAck", RBCP_ACK, 0);
      checkOutput("midRstBusy", BUSY, 0);
      @(negedge CLK);
      RST = 1'b0;
      expCnt = 0;
      checkStatus(ERR_NONE, 32'h0);
      applyStimulus(1'b0, 32'h0002_0005, 8'h00, 1, 1, 2, 1, 1'b1, 8'h5A, 1'b1);
      checkStatus(ERR_NONE, 32'h0);

      $display("[TB] clear coinciding with a failure");
      applyStimulus(1'b0, 32'h1234_0000, 8'h00, 0, 0, 0, 0, 1'b1, 8'hEE, 1'b0);
      expCnt = 1;
      checkStatus(ERR_NODEC, 32'h1234_0000);
      @(negedge CLK);
      RBCP_ADDR = 32'h5555_0000; RBCP_RE = 1'b1; ERR_CLR = 1'b1;
      @(negedge CLK);
      RBCP_RE = 1'b0; ERR_CLR = 1'b0;
      expCnt = 0;
      checkStatus(ERR_NONE, 32'h0);
      repeat (3) @(negedge CLK);

      $display("[TB] error counter saturation");
      RBCP_ADDR = 32'h1234_0000; RBCP_RE = 1'b1;
      repeat (65540) @(negedge CLK);
      RBCP_RE = 1'b0;
      repeat (3) @(negedge CLK);
      checkOutput("satCnt", ERR_CNT, 16'hFFFF);
      checkOutput("satCntB", errCntB, 16'hFFFF);
      ERR_CLR = 1'b1;
      @(negedge CLK);
      ERR_CLR = 1'b0;
      expCnt = 0;
      checkStatus(ERR_NONE, 32'h0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
